conv_layer_sequencer: RTL and testbench

- Top-level sequencer for one conv layer's MAC datapath.
- On `start`, clears the weight address generator, then runs it for the layer's full issue count: NUM_ONE_PIXEL_CYCLE × OUT_FEATURE_WIDTH² × NUM_ONEMULT cycles.
- Produces accumulator strobes (enable/clear/last) aligned to the product latency, supports a downstream stall, and signals completion.
- Sits between the layer top-level FSM and the weight address generator, MAC array and output writer.

---
 rtl/conv_layer_sequencer_pkg.sv | 30 +++
 rtl/conv_layer_sequencer_strobe_delay_line.sv | 30 +++
 rtl/conv_layer_sequencer.sv | 152 +++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_sequencer_pkg.sv
// Shared layer constants and sequencer state encoding for the conv layer datapath.
package conv_layer_sequencer_pkg;

  localparam int unsigned DEF_NUM_ONE_PIXEL_CYCLE   = 13;
  localparam int unsigned DEF_OUT_FEATURE_WIDTH     = 28;
  localparam int unsigned DEF_NUM_ONEMULT           = 6;
  localparam int unsigned DEF_OUTPIXEL_BITWIDTH     = 10;
  localparam int unsigned DEF_NUM_MULTCOMP_BITWIDTH = 3;
  localparam int unsigned DEF_CYC_BITWIDTH          = 5;
  localparam int unsigned DEF_ACC_LAT               = 3;

  localparam int unsigned DEF_OUTPIXEL_COUNT = DEF_OUT_FEATURE_WIDTH * DEF_OUT_FEATURE_WIDTH;
  localparam int unsigned DEF_TOTAL_ISSUE    =
    DEF_NUM_ONE_PIXEL_CYCLE * DEF_OUTPIXEL_COUNT * DEF_NUM_ONEMULT;

  // Encoding is kept stable so the layer-level FSM can decode it directly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } seq_state_e;

  // Pixels in one square output map.
  function automatic int unsigned pixel_count(input int unsigned side);
    return side * side;
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_strobe_delay_line.sv
// Fixed-depth shift register aligning issue-time strobes with product arrival.
module strobe_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift every cycle; asynchronous clear flushes all in-flight strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_layer_sequencer.sv
// Sequences one conv layer: clears the weight generator, issues the full
// cycle/pixel/map schedule, then drains the product pipeline and signals done.
module conv_layer_sequencer
  import conv_layer_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ONE_PIXEL_CYCLE   = DEF_NUM_ONE_PIXEL_CYCLE,
  parameter int unsigned OUT_FEATURE_WIDTH     = DEF_OUT_FEATURE_WIDTH,
  parameter int unsigned NUM_ONEMULT           = DEF_NUM_ONEMULT,
  parameter int unsigned OUTPIXEL_BITWIDTH     = DEF_OUTPIXEL_BITWIDTH,
  parameter int unsigned NUM_MULTCOMP_BITWIDTH = DEF_NUM_MULTCOMP_BITWIDTH,
  parameter int unsigned CYC_BITWIDTH          = DEF_CYC_BITWIDTH,
  parameter int unsigned ACC_LAT               = DEF_ACC_LAT
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             hold,
  output logic                             busy,
  output logic                             done,
  output logic                             wgen_reset,
  output logic                             wgen_enable,
  output logic                             acc_en,
  output logic                             acc_clear,
  output logic                             acc_last,
  output logic [OUTPIXEL_BITWIDTH-1:0]     pix_idx,
  output logic [NUM_MULTCOMP_BITWIDTH-1:0] map_idx
);

  localparam int unsigned OUTPIXEL_COUNT = pixel_count(OUT_FEATURE_WIDTH);
  localparam int unsigned DRAIN_BITWIDTH = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam int unsigned PAYLOAD_W      = 3 + OUTPIXEL_BITWIDTH + NUM_MULTCOMP_BITWIDTH;

  localparam logic [CYC_BITWIDTH-1:0]          CYC_MAX   = CYC_BITWIDTH'(NUM_ONE_PIXEL_CYCLE - 1);
  localparam logic [OUTPIXEL_BITWIDTH-1:0]     PIX_MAX   = OUTPIXEL_BITWIDTH'(OUTPIXEL_COUNT - 1);
  localparam logic [NUM_MULTCOMP_BITWIDTH-1:0] MAP_MAX   = NUM_MULTCOMP_BITWIDTH'(NUM_ONEMULT - 1);
  localparam logic [DRAIN_BITWIDTH-1:0]        DRAIN_MAX = DRAIN_BITWIDTH'(ACC_LAT - 1);

  seq_state_e                       state_q, state_d;
  logic [CYC_BITWIDTH-1:0]          cyc_q, cyc_d;
  logic [OUTPIXEL_BITWIDTH-1:0]     pix_q, pix_d;
  logic [NUM_MULTCOMP_BITWIDTH-1:0] map_q, map_d;
  logic [DRAIN_BITWIDTH-1:0]        drain_q, drain_d;

  logic cyc_last, pix_last, map_last, final_issue;

  logic [PAYLOAD_W-1:0] dl_in, dl_out;

  assign cyc_last    = (cyc_q == CYC_MAX);
  assign pix_last    = (pix_q == PIX_MAX);
  assign map_last    = (map_q == MAP_MAX);
  assign final_issue = cyc_last && pix_last && map_last;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      pix_q   <= '0;
      map_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      pix_q   <= pix_d;
      map_q   <= map_d;
      drain_q <= drain_d;
    end
  end

  // Next-state, nested issue counters and control outputs.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    pix_d       = pix_q;
    map_d       = map_q;
    drain_d     = drain_q;
    busy        = 1'b0;
    done        = 1'b0;
    wgen_reset  = 1'b0;
    wgen_enable = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLR;
      end
      ST_CLR: begin
        busy       = 1'b1;
        wgen_reset = 1'b1;
        cyc_d      = '0;
        pix_d      = '0;
        map_d      = '0;
        drain_d    = '0;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        busy        = 1'b1;
        wgen_enable = !hold;
        if (!hold) begin
          // All three counters wrap together on the final issue so none
          // ever steps past its maximum.
          if (cyc_last) begin
            cyc_d = '0;
            if (pix_last) begin
              pix_d = '0;
              map_d = map_last ? '0 : map_q + 1'b1;
            end else begin
              pix_d = pix_q + 1'b1;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
          if (final_issue) begin
            drain_d = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_q == DRAIN_MAX) begin
          state_d = ST_FIN;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dl_in = {wgen_enable,
                  wgen_enable && (cyc_q == '0),
                  wgen_enable && cyc_last,
                  pix_q,
                  map_q};

  strobe_delay_line #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (ACC_LAT)
  ) u_strobe_delay_line (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (dl_in),
    .q_o     (dl_out)
  );

  assign {acc_en, acc_clear, acc_last, pix_idx, map_idx} = dl_out;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer at a reduced layer size (24 issues)
// plus a second instance with one issue cycle per pixel.
module tb_conv_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, start, hold, start1, hold1;
  logic       busy, done, wgen_reset, wgen_enable, acc_en, acc_clear, acc_last;
  logic [9:0] pix_idx;
  logic [2:0] map_idx;
  logic       busy1, done1, wgen_reset1, wgen_enable1, acc_en1, acc_clear1, acc_last1;
  logic [9:0] pix_idx1;
  logic [2:0] map_idx1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  conv_layer_sequencer #(
    .NUM_ONE_PIXEL_CYCLE   (3),
    .OUT_FEATURE_WIDTH     (2),
    .NUM_ONEMULT           (2),
    .OUTPIXEL_BITWIDTH     (10),
    .NUM_MULTCOMP_BITWIDTH (3),
    .CYC_BITWIDTH          (5),
    .ACC_LAT               (3)
  ) dut (
    .clk (clk), .reset_n (reset_n), .start (start), .hold (hold),
    .busy (busy), .done (done), .wgen_reset (wgen_reset), .wgen_enable (wgen_enable),
    .acc_en (acc_en), .acc_clear (acc_clear), .acc_last (acc_last),
    .pix_idx (pix_idx), .map_idx (map_idx)
  );

  conv_layer_sequencer #(
    .NUM_ONE_PIXEL_CYCLE   (1),
    .OUT_FEATURE_WIDTH     (2),
    .NUM_ONEMULT           (2),
    .OUTPIXEL_BITWIDTH     (10),
    .NUM_MULTCOMP_BITWIDTH (3),
    .CYC_BITWIDTH          (5),
    .ACC_LAT               (3)
  ) dut1 (
    .clk (clk), .reset_n (reset_n), .start (start1), .hold (hold1),
    .busy (busy1), .done (done1), .wgen_reset (wgen_reset1), .wgen_enable (wgen_enable1),
    .acc_en (acc_en1), .acc_clear (acc_clear1), .acc_last (acc_last1),
    .pix_idx (pix_idx1), .map_idx (map_idx1)
  );

  task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected no-hold trace: CLR@1, issues 2..25, acc 5..28, done@29.
  task automatic check_basic(input int c);
    logic e_en;
    int   k;
    e_en = (c >= 5) && (c <= 28);
    check("busy",        c, busy,        (c >= 1) && (c <= 29));
    check("wgen_reset",  c, wgen_reset,  c == 1);
    check("wgen_enable", c, wgen_enable, (c >= 2) && (c <= 25));
    check("done",        c, done,        c == 29);
    check("acc_en",      c, acc_en,      e_en);
    check("acc_clear",   c, acc_clear,   e_en && ((c - 5) % 3 == 0));
    check("acc_last",    c, acc_last,    e_en && ((c - 5) % 3 == 2));
    if (e_en && ((c - 5) % 3 == 2)) begin
      k = (c - 7) / 3;
      check("pix_idx", c, pix_idx, k % 4);
      check("map_idx", c, map_idx, k / 4);
    end
  endtask

  task automatic run_basic();
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    check("pre_busy", 0, busy, 0);
    for (int c = 1; c <= 31; c++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check_basic(c);
    end
  endtask

  initial begin
    int n_we, n_en, n_last, n_done, done_c, k;
    int seq_pix [8];
    int seq_map [8];

    reset_n = 1'b0; start = 1'b0; hold = 1'b0; start1 = 1'b0; hold1 = 1'b0;

    // Reset state
    #12;
    check("rst_busy",        0, busy,        0);
    check("rst_done",        0, done,        0);
    check("rst_wgen_enable", 0, wgen_enable, 0);
    check("rst_wgen_reset",  0, wgen_reset,  0);
    check("rst_acc",         0, {acc_en, acc_clear, acc_last, pix_idx, map_idx}, 0);
    @(negedge clk); reset_n = 1'b1;

    // Basic run and strobe alignment
    run_basic();

    // Stall: hold on cycles 6..9 and on the would-be final issue (29)
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    n_we = 0; n_en = 0; n_last = 0; n_done = 0; done_c = -1; k = 0;
    for (int c = 1; c <= 37; c++) begin
      @(posedge clk); #1 start = 1'b0; hold = ((c >= 6) && (c <= 9)) || (c == 29);
      @(negedge clk);
      if (wgen_enable) n_we++;
      if (acc_en) n_en++;
      if (done) begin n_done++; done_c = c; end
      if (acc_last) begin
        if (k < 8) begin seq_pix[k] = pix_idx; seq_map[k] = map_idx; end
        k++;
      end
      if (c == 29) check("stall_final_held", c, wgen_enable, 0);
      if (c == 30) check("stall_final_issue", c, wgen_enable, 1);
      if (c == 33) check("stall_last_acc", c, acc_en, 1);
      if (c == 34) check("stall_busy_fin", c, busy, 1);
      if (c == 35) check("stall_busy_idle", c, busy, 0);
    end
    hold = 1'b0;
    check("stall_issue_count", 0, n_we,   24);
    check("stall_acc_count",   0, n_en,   24);
    check("stall_done_count",  0, n_done, 1);
    check("stall_done_cycle",  0, done_c, 34);
    check("stall_last_count",  0, k,      8);
    for (int i = 0; i < 8; i++) begin
      check("stall_seq_pix", i, seq_pix[i], i % 4);
      check("stall_seq_map", i, seq_map[i], i / 4);
    end

    // Reset mid-run at cycle 12
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check_basic(c);
    end
    @(posedge clk);
    #1;
    check("pre_rst_acc_en",  12, acc_en,  1);
    check("pre_rst_pix_idx", 12, pix_idx, 2);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_busy",        12, busy,        0);
    check("mid_rst_wgen_enable", 12, wgen_enable, 0);
    check("mid_rst_acc",         12, {acc_en, acc_clear, acc_last, pix_idx, map_idx}, 0);
    n_done = 0;
    for (int c = 13; c <= 15; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mid_rst_no_done", 15, n_done, 0);
    reset_n = 1'b1;
    run_basic();

    // Start handling: ignored pulse at 10, then start held from cycle 20
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    n_done = 0;
    for (int c = 1; c <= 62; c++) begin
      @(posedge clk); #1 start = (c == 10) || (c >= 20);
      @(negedge clk);
      if (done) n_done++;
      if (c <= 29) begin
        check_basic(c);
      end else begin
        check("b2b_busy",       c, busy,       (c != 30) && (c != 60));
        check("b2b_wgen_reset", c, wgen_reset, (c == 31) || (c == 61));
        check("b2b_done",       c, done,       c == 59);
      end
    end
    check("b2b_done_count", 62, n_done, 2);
    start = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    // Degenerate pixel length on the second instance
    @(posedge clk); #1 start1 = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 15; c++) begin
      logic e;
      @(posedge clk); #1 start1 = 1'b0;
      @(negedge clk);
      e = (c >= 5) && (c <= 12);
      check("deg_wgen_enable", c, wgen_enable1, (c >= 2) && (c <= 9));
      check("deg_acc_en",      c, acc_en1,      e);
      check("deg_acc_clear",   c, acc_clear1,   e);
      check("deg_acc_last",    c, acc_last1,    e);
      check("deg_done",        c, done1,        c == 13);
      if (e) begin
        check("deg_pix_idx", c, pix_idx1, (c - 5) % 4);
        check("deg_map_idx", c, map_idx1, (c - 5) / 4);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
